rst_seq: RTL and testbench
==========================

Name: rst_seq

Overview:
- Reset generator and sequencer: the producer side of the design's reset tree.
- Holds all downstream domains in reset until the PLL is locked and a minimum hold time has elapsed.
- Then releases per-stage resets one at a time, in fixed order, with a fixed gap between stages.
- Outputs feed the per-domain reset synchronizers of the video pipeline (memory controller, then pixel pipeline, then HDMI/output stage).

Parameters:
- N_STAGES, 3, number of sequenced reset outputs (1..8).
- HOLD_CYCLES, 16, minimum cycles all resets stay asserted after entering HOLD with lock present (>=1).
- STAGE_GAP, 8, cycles between consecutive stage releases (>=1).
- WDOG_CYCLES, 1000000, lock timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indicator; asynchronous to clk.
- sw_rst_req  in  1  single-cycle software reset request; synchronous to clk.
- rst_out  out  N_STAGES  active-high stage resets; bit 0 is released first.
- seq_done  out  1  high when all stages are released.
- lock_err  out  1  lock watchdog timeout flag; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values (rst_in high): rst_out all ones, seq_done 0, lock_err 0, FSM in HOLD, counters 0, lock synchronizer flops 0.
- rst_in asserts asynchronously. It is released synchronously by the FSM, starting from HOLD.
- pll_locked passes through a 2-flop synchronizer; lock_s is the synchronized value (2-cycle latency).
- All outputs are registered.
- States:
  - HOLD: rst_out all ones. The counter increments while lock_s=1 and clears while lock_s=0. When the counter reaches HOLD_CYCLES-1 with lock_s=1, go to RELEASE with stage index 0 and counter cleared.
  - RELEASE: the first cycle in RELEASE clears rst_out[0]. After that, every STAGE_GAP cycles the next bit is cleared, so rst_out[k] falls k*STAGE_GAP cycles after rst_out[0]. On the cycle the last bit clears, go to RUN.
  - RUN: seq_done=1, rst_out all zeros.
- seq_done rises in the same cycle rst_out[N_STAGES-1] falls.
- Lock loss: lock_s=0 in RELEASE or RUN. Next cycle: rst_out all ones, seq_done 0, FSM in HOLD, counters cleared.
- sw_rst_req=1 in RELEASE or RUN has the same effect as lock loss. sw_rst_req in HOLD restarts the hold count.
- Simultaneous lock loss and sw_rst_req: single return to HOLD; no difference in behaviour.
- Released bits never re-assert individually. Re-assertion is always all stages at once.
- Counter width: $clog2 of max(HOLD_CYCLES, STAGE_GAP)+1. Counters saturate and never wrap.
- N_STAGES=1: rst_out[0] clears and seq_done rises in the same cycle.
- rst_in mid-sequence: immediate return to reset values.

Optional Feature:
- Macro: RST_SEQ_WDOG_EN.
- With the macro:
  - A wdog counter runs while in HOLD with lock_s=0.
  - Reaching WDOG_CYCLES-1 sets lock_err=1 (sticky).
  - lock_err clears only on rst_in or sw_rst_req.
  - The FSM keeps waiting in HOLD; it never releases resets without lock.
- Without the macro: no watchdog logic; lock_err is constant 0.

Decomposition:
- Package rst_seq_pkg:
  - state enum rst_seq_state_t {HOLD, RELEASE, RUN}.
  - Counter-width helper function.
- Sub-module sync2: 2-flop level synchronizer (clk, rst_in active-high, d, q; reset value 0), used for pll_locked.
- The FSM and counters stay in rst_seq.

Test Plan:
1. Power-up, defaults (N_STAGES=3, HOLD_CYCLES=16, STAGE_GAP=8), pll_locked=1 from reset release -> rst_out=3'b111 for 2+16 cycles; then bit0 clears; bit1 clears 8 cycles later; bit2 clears 16 cycles later with seq_done=1 that same cycle.
2. pll_locked held 0 for 100 cycles, then 1 -> rst_out stays 3'b111 throughout; release sequence starts 2+16 cycles after the rise.
3. In RUN, pll_locked drops for 1 cycle (long enough to be sampled) -> rst_out=3'b111 and seq_done=0 three cycles after the drop; full sequence repeats once lock returns.
4. sw_rst_req pulse in RELEASE, after bit0 has cleared and before bit1 -> all bits re-assert next cycle; full sequence repeats from HOLD.
5. rst_in pulsed mid-RELEASE -> outputs go to reset values asynchronously within the same cycle; sequence restarts after rst_in falls.
6. With RST_SEQ_WDOG_EN and WDOG_CYCLES=50, pll_locked=0 -> lock_err=1 at cycle 50 and stays set after lock arrives; sw_rst_req clears it.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the rst_seq reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_t;

    // Width needed to hold the larger of the two counts without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop level synchronizer with active-high asynchronous reset to 0.
module rst_seq_sync2 (
    input  logic clk,
    input  logic rst_in,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Capture the asynchronous level and give it a cycle to settle.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rst_seq.sv
// Reset generator/sequencer: holds all stages until lock plus hold time, then
// releases stage resets in order. Optional lock watchdog: RST_SEQ_WDOG_EN.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_STAGES    = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8
`ifdef RST_SEQ_WDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 1000000
`endif
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                pll_locked,
    input  logic                sw_rst_req,
    output logic [N_STAGES-1:0] rst_out,
    output logic                seq_done,
    output logic                lock_err
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    rst_seq_state_t      state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_STAGES-1:0] rst_out_q;
    logic                seq_done_q;
    logic [N_STAGES-1:0] rel_next_d;
    logic                lock_s;
    logic                abort_s;

    rst_seq_sync2 u_lock_sync (
        .clk    (clk),
        .rst_in (rst_in),
        .d      (pll_locked),
        .q      (lock_s)
    );

    // Releasing the next stage clears the lowest still-asserted bit.
    assign rel_next_d = rst_out_q << 1;
    assign abort_s    = sw_rst_req | ~lock_s;

    // Sequencer FSM with registered stage resets and done flag.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            rst_out_q  <= {N_STAGES{1'b1}};
            seq_done_q <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    rst_out_q  <= {N_STAGES{1'b1}};
                    seq_done_q <= 1'b0;
                    if (abort_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        cnt_q     <= '0;
                        rst_out_q <= rel_next_d;
                        if (rel_next_d == '0) begin
                            state_q    <= RUN;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                RELEASE: begin
                    if (abort_s) begin
                        state_q    <= HOLD;
                        cnt_q      <= '0;
                        rst_out_q  <= {N_STAGES{1'b1}};
                        seq_done_q <= 1'b0;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_q     <= '0;
                        rst_out_q <= rel_next_d;
                        if (rel_next_d == '0) begin
                            state_q    <= RUN;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                RUN: begin
                    cnt_q <= '0;
                    if (abort_s) begin
                        state_q    <= HOLD;
                        rst_out_q  <= {N_STAGES{1'b1}};
                        seq_done_q <= 1'b0;
                    end else begin
                        rst_out_q  <= '0;
                        seq_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= HOLD;
                    cnt_q      <= '0;
                    rst_out_q  <= {N_STAGES{1'b1}};
                    seq_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out  = rst_out_q;
    assign seq_done = seq_done_q;

`ifdef RST_SEQ_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_SAT  = {WD_W{1'b1}};

    logic [WD_W-1:0] wdog_q;
    logic            lock_err_q;

    // Lock watchdog: counts lockless HOLD cycles, error flag is sticky.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            wdog_q     <= '0;
            lock_err_q <= 1'b0;
        end else if (sw_rst_req) begin
            wdog_q     <= '0;
            lock_err_q <= 1'b0;
        end else if ((state_q == HOLD) && !lock_s) begin
            if (wdog_q == WD_LAST) begin
                lock_err_q <= 1'b1;
            end else begin
                lock_err_q <= lock_err_q;
            end
            if (wdog_q != WD_SAT) begin
                wdog_q <= wdog_q + 1'b1;
            end else begin
                wdog_q <= wdog_q;
            end
        end else begin
            wdog_q     <= '0;
            lock_err_q <= lock_err_q;
        end
    end

    assign lock_err = lock_err_q;
`else
    assign lock_err = 1'b0;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: cycle model plus pinned directed checks.
module tb_rst_seq;

    localparam int unsigned N    = 3;
    localparam int unsigned HOLD = 16;
    localparam int unsigned GAP  = 8;
    localparam int unsigned WDOG = 50;
`ifdef RST_SEQ_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_in;
    logic         pll_locked;
    logic         sw_rst_req;
    logic [N-1:0] rst_out;
    logic         seq_done;
    logic         lock_err;

    int checks   = 0;
    int failures = 0;

    rst_seq #(
        .N_STAGES    (N),
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP)
`ifdef RST_SEQ_WDOG_EN
        ,
        .WDOG_CYCLES (WDOG)
`endif
    ) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .pll_locked (pll_locked),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .seq_done   (seq_done),
        .lock_err   (lock_err)
    );

    always #5 clk = ~clk;

    // Model: cycles since reset, delayed lock, qualified-lock run length,
    // cycles since the first stage release, lockless-hold run length.
    int unsigned cyc;
    bit          m_ff1, m_ls, m_seq, m_err;
    int unsigned m_hold, m_trel, m_wd;

    always @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            cyc <= 0; m_ff1 <= 1'b0; m_ls <= 1'b0; m_seq <= 1'b0;
            m_hold <= 0; m_trel <= 0; m_wd <= 0; m_err <= 1'b0;
        end else begin
            cyc   <= cyc + 1;
            m_ff1 <= pll_locked;
            m_ls  <= m_ff1;
            if (sw_rst_req) begin
                m_wd <= 0; m_err <= 1'b0;
            end else if (!m_seq && !m_ls) begin
                m_wd <= m_wd + 1;
                if (m_wd + 1 >= WDOG) m_err <= 1'b1;
            end else begin
                m_wd <= 0;
            end
            if (!m_seq) begin
                if (sw_rst_req || !m_ls) m_hold <= 0;
                else if (m_hold + 1 >= HOLD) begin
                    m_seq <= 1'b1; m_trel <= 0; m_hold <= 0;
                end else m_hold <= m_hold + 1;
            end else if (sw_rst_req || !m_ls) begin
                m_seq <= 1'b0; m_hold <= 0;
            end else if (m_trel < 100000) begin
                m_trel <= m_trel + 1;
            end
        end
    end

    function automatic logic [N-1:0] exp_out();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = !(m_seq && (m_trel >= k * GAP));
        return v;
    endfunction

    function automatic logic exp_done();
        return m_seq && (m_trel >= (N - 1) * GAP);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Every-cycle comparison against the model outside reset.
    always @(negedge clk) begin
        if (!rst_in) begin
            chk("model_rst_out", 32'(rst_out), 32'(exp_out()));
            chk("model_seq_done", 32'(seq_done), 32'(exp_done()));
            chk("model_lock_err", 32'(lock_err), 32'(WD_EN ? m_err : 1'b0));
        end
    end

    task automatic wait_cyc(input int unsigned k);
        int unsigned guard;
        guard = 0;
        while (cyc < k && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < k) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout: got cyc=%0d expected %0d", cyc, k);
        end
    endtask

    task automatic pin(input string name, input logic [N-1:0] ro, input logic sd);
        chk({name, "_rst_out"}, 32'(rst_out), 32'(ro));
        chk({name, "_seq_done"}, 32'(seq_done), 32'(sd));
    endtask

    initial begin
        rst_in = 1'b0; pll_locked = 1'b1; sw_rst_req = 1'b0;
        #2 rst_in = 1'b1;
        @(negedge clk); @(negedge clk);
        pin("reset", 3'b111, 1'b0);
        chk("reset_lock_err", 32'(lock_err), 32'd0);
        rst_in = 1'b0;

        // Power-up with lock present.
        wait_cyc(17); pin("t1_c17", 3'b111, 1'b0);
        wait_cyc(18); pin("t1_c18", 3'b110, 1'b0);
        wait_cyc(25); pin("t1_c25", 3'b110, 1'b0);
        wait_cyc(26); pin("t1_c26", 3'b100, 1'b0);
        wait_cyc(33); pin("t1_c33", 3'b100, 1'b0);
        wait_cyc(34); pin("t1_c34", 3'b000, 1'b1);
        wait_cyc(40);

        // Lock absent for 100 cycles, then present; watchdog meanwhile.
        rst_in = 1'b1;
        @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        rst_in = 1'b0;
        wait_cyc(49);  chk("t6_c49_lock_err", 32'(lock_err), 32'd0);
        wait_cyc(50);  chk("t6_c50_lock_err", 32'(lock_err), 32'(WD_EN));
        wait_cyc(100); pin("t2_c100", 3'b111, 1'b0);
        pll_locked = 1'b1;
        wait_cyc(117); pin("t2_c117", 3'b111, 1'b0);
        wait_cyc(118); pin("t2_c118", 3'b110, 1'b0);
        wait_cyc(134); pin("t2_c134", 3'b000, 1'b1);
        chk("t6_sticky_lock_err", 32'(lock_err), 32'(WD_EN));

        // One-cycle lock drop in RUN.
        wait_cyc(140); pll_locked = 1'b0;
        wait_cyc(141); pll_locked = 1'b1;
        wait_cyc(142); pin("t3_c142", 3'b000, 1'b1);
        wait_cyc(143); pin("t3_c143", 3'b111, 1'b0);
        wait_cyc(158); pin("t3_c158", 3'b111, 1'b0);
        wait_cyc(159); pin("t3_c159", 3'b110, 1'b0);

        // Software reset between bit0 and bit1 release.
        wait_cyc(162); sw_rst_req = 1'b1;
        wait_cyc(163); sw_rst_req = 1'b0;
        pin("t4_c163", 3'b111, 1'b0);
        chk("t6_sw_clear_lock_err", 32'(lock_err), 32'd0);
        wait_cyc(178); pin("t4_c178", 3'b111, 1'b0);
        wait_cyc(179); pin("t4_c179", 3'b110, 1'b0);

        // Asynchronous reset mid-release.
        wait_cyc(182);
        #2 rst_in = 1'b1;
        #1 pin("t5_async", 3'b111, 1'b0);
        chk("t5_async_lock_err", 32'(lock_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_in = 1'b0;
        wait_cyc(18); pin("t5_c18", 3'b110, 1'b0);
        wait_cyc(34); pin("t5_c34", 3'b000, 1'b1);
        wait_cyc(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
